reg_wr_sched: RTL and testbench
===============================

# reg_wr_sched

Write-port scheduler for the 8-entry, 8-bit register file. It shares the file's single write port between two requesters: the ALU writeback path and the memory-load return path. It buffers loads that lose arbitration, preserves write ordering, and prevents load starvation. It exports per-register busy bits so the decoder can hold reads of registers with a queued pending write. It sits between the execute/memory stages and the register file's `wr_en`/`wr_addr`/`dat_in` inputs.

## Interface
- `DW`, 8, data width
- `AW`, 3, register address width (2**AW registers)
- `QD`, 2, load queue depth (entries, ≥1)
- `STARVE`, 4, cycles a queued load may lose before it is forced to win (≥1)

- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `alu_valid`  in  1  ALU write request
- `alu_addr`  in  AW  ALU destination register
- `alu_data`  in  DW  ALU result
- `alu_ready`  out  1  ALU request accepted this cycle when high with `alu_valid`
- `ld_valid`  in  1  load return request
- `ld_addr`  in  AW  load destination register
- `ld_data`  in  DW  load data
- `ld_ready`  out  1  low when the load queue is full
- `wr_en`  out  1  register-file write enable (registered)
- `wr_addr`  out  AW  register-file write address (registered)
- `wr_data`  out  DW  register-file write data (registered)
- `busy`  out  2**AW  bit i is set while any queued load targets register i
- `pend_cnt`  out  $clog2(QD+1)  number of queued loads

## Operation
- Load queue: a FIFO of {addr, data}, depth QD. A load is accepted when `ld_valid && ld_ready` and is always enqueued; loads never bypass the queue.
- Head age counter: increments each cycle the queue is non-empty and the head is not dequeued. It clears on dequeue and on reset.
- Arbitration, evaluated each cycle (one winner at most):
  - Force-load when the queue is non-empty and age == STARVE. The head wins and `alu_ready` = 0.
  - Otherwise, if `alu_valid` and no hazard, the ALU wins.
  - Otherwise, if the queue is non-empty, the head wins.
- Hazard: `alu_addr` matches the address of any queued entry. Then `alu_ready` = 0 and the head drains. This keeps the older load write ahead of the younger ALU write.
- `alu_ready` = reset_n && !force-load && !hazard. It is combinational from the inputs and queue state.
- `ld_ready` = reset_n && (pend_cnt < QD). It does not depend on a same-cycle dequeue.
- Registers 0 and 1 are hardwired in the file:
  - A winner targeting addr 0 or 1 completes its handshake/dequeue, but `wr_en` stays 0 for that slot.
  - Loads targeting addr 0 or 1 still occupy a queue entry and set `busy`.
- `busy` is the OR of a one-hot decode over all valid queue entries. It updates on the edge after enqueue or dequeue.
- Simultaneous enqueue and dequeue: `pend_cnt` is unchanged, the head advances, and the new entry goes to the tail.
- Reset (any cycle, including mid-drain):
  - Queue is emptied and the age counter cleared.
  - `wr_en`/`wr_addr`/`wr_data`, `busy`, and `pend_cnt` = 0.
  - `alu_ready` = `ld_ready` = 0 while `reset_n` is low. In-flight requests are discarded.

## Timing
- ALU accepted in cycle N: `wr_en`/`wr_addr`/`wr_data` are valid in cycle N+1 (visible in the file after edge N+1→N+2).
- Load accepted in cycle N: it is at the queue head from N+1 at the earliest, so `wr_en` is earliest at N+2.
- `pend_cnt` and `busy` reflect an enqueue from N+1.
- Throughput: one register write per cycle maximum.
- A stalled ALU requester holds `alu_valid`/`alu_addr`/`alu_data` stable until accepted. A held load holds its inputs while `ld_ready` = 0.
- Worst-case ALU stall per queued load: one cycle (force or hazard drain). Worst-case load wait at the head: STARVE cycles.

## Test plan
- Reset release, ALU `alu_valid`=1, addr 3, data 0x5A, one cycle → `alu_ready`=1; next cycle `wr_en`=1, `wr_addr`=3, `wr_data`=0x5A.
- `alu_valid` (addr 4, 0x11) and `ld_valid` (addr 2, 0x22) in the same cycle, ALU idle afterward → ALU write at N+1, load write at N+2. `busy[2]`=1 during N+1 only.
- Continuous ALU traffic to addr 5 with one load (addr 2, 0x77) queued → `alu_ready` drops exactly once, after STARVE (4) losing cycles. The load write occurs that slot, then the ALU resumes.
- Two loads queued (addr 6), QD=2 → `ld_ready`=0 and `pend_cnt`=2. ALU request to addr 6 is stalled (hazard) until both drain, then writes last; final reg6 = ALU data.
- ALU write to addr 0 (0xFF) and load to addr 1 → both handshakes complete, `wr_en` never asserts, `pend_cnt` returns to 0.
- Assert `reset_n`=0 with 2 queued loads → next cycle `pend_cnt`=0, `busy`=0, `wr_en`=0, `ld_ready`=`alu_ready`=0. After release, no stale write appears.

Source files
------------

// File: rtl/reg_wr_sched.sv
// Write-port scheduler: arbitrates ALU writeback and queued load returns onto one register-file write port.
// ALU write lands one cycle after acceptance; loads wait in an in-order queue and are force-drained after STARVE losses.
module reg_wr_sched #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int QD     = 2,
  parameter int STARVE = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  input  logic [AW-1:0]          alu_addr,
  input  logic [DW-1:0]          alu_data,
  output logic                   alu_ready,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_addr,
  input  logic [DW-1:0]          ld_data,
  output logic                   ld_ready,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [DW-1:0]          wr_data,
  output logic [(2**AW)-1:0]     busy,
  output logic [$clog2(QD+1)-1:0] pend_cnt
);

  localparam int CW  = $clog2(QD + 1);
  localparam int AGW = $clog2(STARVE + 1);

  // Shift-register queue: entry 0 is always the head.
  logic [AW-1:0]  r_q_addr [QD];
  logic [DW-1:0]  r_q_data [QD];
  logic [CW-1:0]  r_cnt;
  logic [AGW-1:0] r_age;

  logic            w_hazard;
  logic [(2**AW)-1:0] w_busy;
  logic            w_nonempty;
  logic            w_force;
  logic            w_alu_win;
  logic            w_deq;
  logic            w_enq;
  logic            w_win;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_data;
  logic [CW-1:0]   w_wr_idx;

  always_comb begin
    w_hazard = 1'b0;
    w_busy   = '0;
    for (int i = 0; i < QD; i++) begin
      if (CW'(i) < r_cnt) begin
        if (r_q_addr[i] == alu_addr) w_hazard = 1'b1;
        w_busy[r_q_addr[i]] = 1'b1;
      end
    end
  end

  assign w_nonempty = (r_cnt != '0);
  assign w_force    = w_nonempty && (r_age == AGW'(STARVE));
  assign alu_ready  = reset_n && !w_force && !w_hazard;
  assign ld_ready   = reset_n && (r_cnt < CW'(QD));

  assign w_alu_win  = alu_valid && alu_ready;
  assign w_deq      = reset_n && w_nonempty && !w_alu_win;
  assign w_enq      = ld_valid && ld_ready;
  assign w_win      = w_alu_win || w_deq;
  assign w_win_addr = w_alu_win ? alu_addr : r_q_addr[0];
  assign w_win_data = w_alu_win ? alu_data : r_q_data[0];
  assign w_wr_idx   = r_cnt - CW'(w_deq);

  assign busy     = w_busy;
  assign pend_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_age   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (w_deq) begin
        for (int i = 0; i < QD - 1; i++) begin
          r_q_addr[i] <= r_q_addr[i+1];
          r_q_data[i] <= r_q_data[i+1];
        end
      end
      // Tail slot accounts for a same-cycle head advance.
      if (w_enq) begin
        for (int i = 0; i < QD; i++) begin
          if (i == int'(w_wr_idx)) begin
            r_q_addr[i] <= ld_addr;
            r_q_data[i] <= ld_data;
          end
        end
      end
      r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);

      if (w_deq)           r_age <= '0;
      else if (w_nonempty) r_age <= r_age + AGW'(1);

      // Registers 0 and 1 are hardwired: the slot is consumed but nothing is written.
      wr_en <= w_win && (w_win_addr >= AW'(2));
      if (w_win) begin
        wr_addr <= w_win_addr;
        wr_data <= w_win_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wr_sched.sv
// Directed bench for reg_wr_sched: reset, ALU path, load queue ordering, starvation, hazard, hardwired regs.
module tb_reg_wr_sched;

  logic       clk;
  logic       reset_n;
  logic       alu_valid;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_ready;
  logic       ld_valid;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] busy;
  logic [1:0] pend_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  reg_wr_sched #(.DW(8), .AW(3), .QD(2), .STARVE(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .pend_cnt  (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    cyc(); cyc();
    n_tests++;
    if ({wr_en, pend_cnt, busy, alu_ready, ld_ready} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h exp 0", {wr_en, pend_cnt, busy, alu_ready, ld_ready});
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if ({alu_ready, ld_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b exp 11", {alu_ready, ld_ready});
    end
  endtask

  task automatic test_alu_basic();
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 8'h5A;
    #1;
    n_tests++;
    if (alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL alu_basic_ready got %b exp 1", alu_ready);
    end
    cyc();
    idle();
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd3, 8'h5A}) begin
      n_fail++; $display("FAIL alu_basic_write got %b/%0d/%h exp 1/3/5a", wr_en, wr_addr, wr_data);
    end
    cyc();
    n_tests++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL alu_basic_idle got wr_en=%b exp 0", wr_en);
    end
  endtask

  task automatic test_alu_and_load();
    alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 8'h11;
    ld_valid  = 1'b1; ld_addr  = 3'd2; ld_data  = 8'h22;
    cyc();
    idle();
    n_tests++;
    if ({wr_en, wr_addr, wr_data, busy, pend_cnt} !== {1'b1, 3'd4, 8'h11, 8'h04, 2'd1}) begin
      n_fail++;
      $display("FAIL alu_load_first got en=%b a=%0d d=%h busy=%h pend=%0d exp 1/4/11/04/1",
               wr_en, wr_addr, wr_data, busy, pend_cnt);
    end
    cyc();
    n_tests++;
    if ({wr_en, wr_addr, wr_data, busy, pend_cnt} !== {1'b1, 3'd2, 8'h22, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL alu_load_second got en=%b a=%0d d=%h busy=%h pend=%0d exp 1/2/22/00/0",
               wr_en, wr_addr, wr_data, busy, pend_cnt);
    end
    cyc();
  endtask

  task automatic test_starve();
    logic [7:0] rdy;
    logic [2:0] wa [8];
    logic [7:0] wd [8];
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 8'h33;
    ld_valid  = 1'b1; ld_addr  = 3'd2; ld_data  = 8'h77;
    for (int c = 0; c < 8; c++) begin
      #1;
      rdy[c] = alu_ready;
      cyc();
      ld_valid = 1'b0;
      wa[c] = wr_addr;
      wd[c] = wr_data;
    end
    idle();
    cyc();
    n_tests++;
    if (rdy !== 8'hDF) begin
      n_fail++; $display("FAIL starve_ready_pattern got %b exp 11011111", rdy);
    end
    n_tests++;
    if ({wa[4], wa[5], wd[5], wa[6]} !== {3'd5, 3'd2, 8'h77, 3'd5}) begin
      n_fail++;
      $display("FAIL starve_write_order got %0d,%0d/%h,%0d exp 5,2/77,5", wa[4], wa[5], wd[5], wa[6]);
    end
    n_tests++;
    if (pend_cnt !== 2'd0) begin
      n_fail++; $display("FAIL starve_drained got pend=%0d exp 0", pend_cnt);
    end
  endtask

  task automatic test_hazard_full();
    logic [2:0] wa [5];
    logic [7:0] wd [5];
    logic [4:0] rdy;
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 8'hB0;
    ld_valid  = 1'b1; ld_addr  = 3'd6; ld_data  = 8'hA1;
    #1; rdy[0] = alu_ready;
    cyc(); wa[0] = wr_addr; wd[0] = wr_data;
    alu_data = 8'hB1; ld_data = 8'hA2;
    #1; rdy[1] = alu_ready;
    cyc(); wa[1] = wr_addr; wd[1] = wr_data;
    ld_valid = 1'b0;
    n_tests++;
    if ({ld_ready, pend_cnt, busy} !== {1'b0, 2'd2, 8'h40}) begin
      n_fail++;
      $display("FAIL hazard_full got ld_ready=%b pend=%0d busy=%h exp 0/2/40", ld_ready, pend_cnt, busy);
    end
    alu_addr = 3'd6; alu_data = 8'hC6;
    for (int c = 2; c < 5; c++) begin
      #1; rdy[c] = alu_ready;
      cyc(); wa[c] = wr_addr; wd[c] = wr_data;
    end
    idle();
    n_tests++;
    if (rdy !== 5'b10011) begin
      n_fail++; $display("FAIL hazard_ready_pattern got %b exp 10011", rdy);
    end
    n_tests++;
    if ({wa[2], wd[2], wa[3], wd[3], wa[4], wd[4]} !== {3'd6, 8'hA1, 3'd6, 8'hA2, 3'd6, 8'hC6}) begin
      n_fail++;
      $display("FAIL hazard_order got %h,%h,%h exp a1,a2,c6 (all addr 6)", wd[2], wd[3], wd[4]);
    end
    n_tests++;
    if ({wa[0], wd[0], wa[1], wd[1]} !== {3'd5, 8'hB0, 3'd5, 8'hB1}) begin
      n_fail++; $display("FAIL hazard_prefill got %h,%h exp b0,b1", wd[0], wd[1]);
    end
    cyc();
    n_tests++;
    if ({wr_en, pend_cnt, busy} !== 11'h0) begin
      n_fail++; $display("FAIL hazard_idle got en=%b pend=%0d busy=%h exp 0", wr_en, pend_cnt, busy);
    end
  endtask

  task automatic test_hardwired();
    logic any_wr;
    alu_valid = 1'b1; alu_addr = 3'd0; alu_data = 8'hFF;
    ld_valid  = 1'b1; ld_addr  = 3'd1; ld_data  = 8'h44;
    #1;
    n_tests++;
    if ({alu_ready, ld_ready} !== 2'b11) begin
      n_fail++; $display("FAIL hardwired_handshake got %b exp 11", {alu_ready, ld_ready});
    end
    cyc();
    idle();
    any_wr = wr_en;
    n_tests++;
    if ({pend_cnt, busy} !== {2'd1, 8'h02}) begin
      n_fail++; $display("FAIL hardwired_queued got pend=%0d busy=%h exp 1/02", pend_cnt, busy);
    end
    cyc();
    any_wr = any_wr | wr_en;
    n_tests++;
    if ({any_wr, pend_cnt} !== 3'b000) begin
      n_fail++; $display("FAIL hardwired_no_write got wr=%b pend=%0d exp 0/0", any_wr, pend_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic stale;
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 8'hD0;
    ld_valid  = 1'b1; ld_addr  = 3'd6; ld_data  = 8'hE1;
    cyc();
    ld_data = 8'hE2;
    cyc();
    idle();
    n_tests++;
    if (pend_cnt !== 2'd2) begin
      n_fail++; $display("FAIL reset_mid_prefill got pend=%0d exp 2", pend_cnt);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({alu_ready, ld_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_ready got %b exp 00", {alu_ready, ld_ready});
    end
    cyc();
    n_tests++;
    if ({wr_en, pend_cnt, busy} !== 11'h0) begin
      n_fail++; $display("FAIL reset_mid_clear got en=%b pend=%0d busy=%h exp 0", wr_en, pend_cnt, busy);
    end
    reset_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      stale = stale | wr_en;
    end
    n_tests++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_stale got wr_en seen=%b exp 0", stale);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_alu_basic();
    test_alu_and_load();
    test_starve();
    test_hazard_full();
    test_hardwired();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
